mips_fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of `datapath_debug`. It owns the program counter and issues word requests to instruction memory over a ready/valid handshake. Returned words are buffered in a small prefetch FIFO tagged with their PC, and handed to the datapath one per accepted handshake. A branch or jump redirect from the datapath flushes the FIFO and squashes any in-flight memory responses.

---
 rtl/mips_fetch_unit.sv | 120 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and
// buffers PC-tagged responses in a prefetch FIFO. Optional FETCH_ALIGN_CHECK_EN.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] squash_cnt;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          halted;
  logic [31:0]   target_pc;
  logic [CW:0]   credit_used;
  logic          accept;
  logic          push;
  logic          pop;
  logic          drop;

  // Every FIFO slot is either filled or owed by an in-flight request, so the
  // FIFO can never overflow when the response finally returns.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = rst_n && !redirect && !halted && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign drop        = imem_rvalid && (squash_cnt != '0);
  assign push        = imem_rvalid && (squash_cnt == '0) && !redirect;
  assign pop         = (count != '0) && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_pc = redirect_pc;
  assign halted    = misalign_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign target_pc    = redirect_pc & 32'hFFFF_FFFC;
  assign halted       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      squash_cnt  <= '0;
    end else begin
      // No request is accepted in a redirect cycle, so one update covers both.
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc   <= target_pc;
        resp_pc    <= target_pc;
        squash_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   resp_pc  <= resp_pc + 32'd4;
        if (drop)   squash_cnt <= squash_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= RESET_PC;
        instr_mem[i] <= 32'h0;
      end
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= resp_pc;
        instr_mem[wr_ptr] <= imem_rdata;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: cycle table for streaming/backpressure,
// hand sequences for redirects, wrap-around and misaligned targets.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;

  mips_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .misalign_err (misalign_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;
  mem_t mq[$];

  logic [31:0] exp_q[$];

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;
  logic [31:0] obs_instr;
  logic        obs_err;

  typedef struct {
    logic        irdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, let the
  // rising edge happen, return at the next falling edge.
  task automatic tick(input logic rdy, input logic irdy, input logic redir,
                      input logic [31:0] rpc);
    mem_t        m;
    logic [31:0] e;
    imem_ready  = rdy;
    instr_ready = irdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = instr_valid;
    obs_pc    = instr_pc;
    obs_instr = instr;
    obs_err   = misalign_err;
    if (imem_req && imem_ready) begin
      m.addr = imem_addr;
      m.due  = cyc + lat;
      mq.push_back(m);
    end
    if (imem_rvalid) void'(mq.pop_front());
    // scoreboard: every delivered instruction must be the next expected PC
    if (instr_valid && instr_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_deliv: got pc %08h expected no delivery (cycle %0d)", instr_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("deliv_pc", instr_pc, e);
        chk("deliv_instr", instr, mem_word(e));
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    mq.delete();
    chk("pending_deliveries", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    // streaming from reset (rows 0-5), then backpressure against a full FIFO
    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vt[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vt[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    vt[8]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[9]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[10] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
    vt[11] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
    vt[12] = '{1'b0, 1'b0, 32'h24, 1'b1, 32'h14};
    vt[13] = '{1'b0, 1'b0, 32'h24, 1'b1, 32'h14};
    #2;

    // table-driven: reset fetch and backpressure
    do_reset();
    lat = 1;
    exp_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    for (int i = 0; i < 14; i++) begin
      tick(1'b1, vt[i].irdy, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req", i), 32'(obs_req), 32'(vt[i].exp_req));
      chk($sformatf("tbl%0d_addr", i), obs_addr, vt[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(obs_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), obs_pc, vt[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), obs_instr, mem_word(vt[i].exp_pc));
      end
    end

    // redirect with two responses in flight, memory latency 3
    do_reset();
    lat = 3;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("inflight_req0", obs_addr, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("inflight_req1", obs_addr, 32'h4);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    chk("inflight_redir_req", 32'(obs_req), 32'd0);
    exp_q = '{32'h100, 32'h104, 32'h108};
    for (int i = 0; i < 4; i++) begin
      tick((i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("inflight_empty%0d", i), 32'(obs_valid), 32'd0);
      if (i == 0) begin
        chk("inflight_new_req", 32'(obs_req), 32'd1);
        chk("inflight_new_addr", obs_addr, 32'h100);
      end
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect coincident with a response and a pop
    do_reset();
    lat = 1;
    exp_q = '{32'h00, 32'h40, 32'h44};
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    chk("coinc_head_valid", 32'(obs_valid), 32'd1);
    chk("coinc_redir_req", 32'(obs_req), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coinc_flushed", 32'(obs_valid), 32'd0);
    chk("coinc_new_addr", obs_addr, 32'h40);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coinc_still_empty", 32'(obs_valid), 32'd0);
    chk("coinc_next_addr", obs_addr, 32'h44);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);

    // PC wrap-around
    do_reset();
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr0", obs_addr, 32'hFFFF_FFF8);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr1", obs_addr, 32'hFFFF_FFFC);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr2", obs_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);

    // misaligned redirect
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("mis_halt_req%0d", i), 32'(obs_req), 32'd0);
      chk($sformatf("mis_err%0d", i), 32'(obs_err), 32'd1);
    end
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mis_resume_req", 32'(obs_req), 32'd1);
    chk("mis_resume_addr", obs_addr, 32'h0);
`else
    exp_q = '{32'h100, 32'h104};
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_addr0", obs_addr, 32'h100);
    chk("mis_err_low", 32'(obs_err), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_addr1", obs_addr, 32'h104);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
`endif

    // final reset also verifies every expected delivery was consumed
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
